// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master, one-slave round-robin arbiter for the CPU memory bus.
// One outstanding transaction at a time. A watchdog force-completes any
// transaction whose slave has not answered within TIMEOUT BUSY cycles.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   m0_* / m1_*                master request (valid/instr/addr/wdata/wstrb)
//                              and response (rdata/ready, combinational)
//   s_*                        downstream request (registered) and response
//   err_timeout                one-cycle pulse on forced termination
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,
    output logic        err_timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic        req_instr_q, req_instr_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] req_wdata_q, req_wdata_d;
    logic [3:0]  req_wstrb_q, req_wstrb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        s_valid_q, s_valid_d;

    logic        grant_m1;
    logic        done_ok;
    logic        timeout;

    // Arbitration, completion/timeout detection and master-side responses
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        req_instr_d = req_instr_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        cnt_d       = cnt_q;
        s_valid_d   = 1'b0;
        grant_m1    = 1'b0;
        done_ok     = 1'b0;
        timeout     = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    // On a tie the master that did not win last time goes first
                    grant_m1    = (m0_valid && m1_valid) ? ~last_q : m1_valid;
                    gnt_d       = grant_m1;
                    last_d      = grant_m1;
                    req_instr_d = grant_m1 ? m1_instr : m0_instr;
                    req_addr_d  = grant_m1 ? m1_addr  : m0_addr;
                    req_wdata_d = grant_m1 ? m1_wdata : m0_wdata;
                    req_wstrb_d = grant_m1 ? m1_wstrb : m0_wstrb;
                    s_valid_d   = 1'b1;
                    cnt_d       = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                // A real answer beats a timeout landing in the same cycle
                if (s_ready) begin
                    done_ok = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        m0_ready    = (done_ok || timeout) && !gnt_q;
        m1_ready    = (done_ok || timeout) &&  gnt_q;
        m0_rdata    = (done_ok && !gnt_q) ? s_rdata : 32'h0;
        m1_rdata    = (done_ok &&  gnt_q) ? s_rdata : 32'h0;
        err_timeout = timeout;
    end

    // State and captured-request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            req_instr_q <= 1'b0;
            req_addr_q  <= 32'h0;
            req_wdata_q <= 32'h0;
            req_wstrb_q <= 4'h0;
            cnt_q       <= '0;
            s_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            req_instr_q <= req_instr_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            cnt_q       <= cnt_d;
            s_valid_q   <= s_valid_d;
        end
    end

    assign s_valid = s_valid_q;
    assign s_instr = req_instr_q;
    assign s_addr  = req_addr_q;
    assign s_wdata = req_wdata_q;
    assign s_wstrb = req_wstrb_q;

endmodule
